sysreg_access_arbiter: RTL and testbench

//  Shares the single system-register star port between NREQ requesters (req 0 = core, req 1 = debug).

---
 rtl/sysreg_access_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_sysreg_access_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysreg_access_arbiter.sv
// Round-robin arbiter sharing the system-register star port between NREQ requesters,
// with privilege check, single bus strobe per transaction and read timeout.
module sysreg_access_arbiter #(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] PRIV_MASK = 32'h400
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*5-1:0]    req_group,
    input  logic [NREQ*3-1:0]    req_regnum,
    input  logic [NREQ*2-1:0]    req_plevel,
    input  logic [NREQ*64-1:0]   req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [63:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 sr_rd_en,
    output logic                 sr_wr_en,
    output logic [4:0]           sr_group,
    output logic [2:0]           sr_regnum,
    output logic [1:0]           sr_plevel,
    output logic [63:0]          sr_wr_val,
    input  logic                 sr_rd_valid,
    input  logic [63:0]          sr_rd_val
);

    localparam int unsigned   PW       = $clog2(NREQ);
    localparam int unsigned   PW1      = PW + 1;
    localparam int unsigned   CW       = $clog2(TIMEOUT) + 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
    localparam logic [PW:0]   NREQ_W   = PW1'(NREQ);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic            r_write;
    logic            r_denied;
    logic [CW-1:0]   r_cnt;
    logic            r_rd_en;
    logic            r_wr_en;
    logic [4:0]      r_group;
    logic [2:0]      r_regnum;
    logic [1:0]      r_plevel;
    logic [63:0]     r_wr_val;
    logic [NREQ-1:0] r_rsp_valid;
    logic [63:0]     r_rsp_rdata;
    logic            r_rsp_err;

    logic            w_found;
    logic [PW-1:0]   w_winner;
    logic [PW:0]     w_sum;
    logic [PW-1:0]   w_idx;
    logic            w_write;
    logic [4:0]      w_group;
    logic [2:0]      w_regnum;
    logic [1:0]      w_plevel;
    logic [63:0]     w_wdata;
    logic            w_denied;
    logic [NREQ-1:0] w_owner_oh;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + PW1'(k);
            w_idx = (w_sum >= NREQ_W) ? PW'(w_sum - NREQ_W) : PW'(w_sum);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_write    = 1'b0;
        w_group    = '0;
        w_regnum   = '0;
        w_plevel   = '0;
        w_wdata    = '0;
        w_owner_oh = '0;
        req_ready  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_winner == PW'(i)) begin
                w_write  = req_write[i];
                w_group  = req_group[5*i +: 5];
                w_regnum = req_regnum[3*i +: 3];
                w_plevel = req_plevel[2*i +: 2];
                w_wdata  = req_wdata[64*i +: 64];
            end
            w_owner_oh[i] = (r_owner == PW'(i));
            req_ready[i]  = rst_n && (r_state == S_IDLE) && w_found && (w_winner == PW'(i));
        end
        w_denied = PRIV_MASK[w_group] && (w_plevel != 2'd0);
    end

    // Denied requests still spend the ISSUE cycle (strobes suppressed) so that
    // their response lands at the same handshake+2 slot as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_write     <= 1'b0;
            r_denied    <= 1'b0;
            r_cnt       <= '0;
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_group     <= '0;
            r_regnum    <= '0;
            r_plevel    <= '0;
            r_wr_val    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner  <= w_winner;
                        r_ptr    <= (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;
                        r_write  <= w_write;
                        r_denied <= w_denied;
                        r_group  <= w_group;
                        r_regnum <= w_regnum;
                        r_plevel <= w_plevel;
                        r_wr_val <= w_wdata;
                        r_wr_en  <= !w_denied && w_write;
                        r_rd_en  <= !w_denied && !w_write;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_denied || r_write) begin
                        r_rsp_valid <= w_owner_oh;
                        r_rsp_err   <= r_denied;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sr_rd_valid) begin
                        r_rsp_valid <= w_owner_oh;
                        r_rsp_rdata <= sr_rd_val;
                        r_state     <= S_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rsp_valid <= w_owner_oh;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign sr_rd_en  = r_rd_en;
    assign sr_wr_en  = r_wr_en;
    assign sr_group  = r_group;
    assign sr_regnum = r_regnum;
    assign sr_plevel = r_plevel;
    assign sr_wr_val = r_wr_val;

endmodule

// File: tb/tb_sysreg_access_arbiter.sv
// Bench for sysreg_access_arbiter: transaction-level latency model plus directed literal checks.
module tb_sysreg_access_arbiter;

    localparam int          NREQ      = 2;
    localparam int          TIMEOUT   = 16;
    localparam logic [31:0] PRIV_MASK = 32'h400;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_write = '0;
    logic [NREQ*5-1:0]   req_group = '0;
    logic [NREQ*3-1:0]   req_regnum = '0;
    logic [NREQ*2-1:0]   req_plevel = '0;
    logic [NREQ*64-1:0]  req_wdata = '0;
    logic [NREQ-1:0]     rsp_valid;
    logic [63:0]         rsp_rdata;
    logic                rsp_err;
    logic                sr_rd_en, sr_wr_en;
    logic [4:0]          sr_group;
    logic [2:0]          sr_regnum;
    logic [1:0]          sr_plevel;
    logic [63:0]         sr_wr_val;
    logic                sr_rd_valid = 1'b0;
    logic [63:0]         sr_rd_val = '0;

    always #5 clk = ~clk;

    sysreg_access_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .PRIV_MASK(PRIV_MASK)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_group(req_group), .req_regnum(req_regnum), .req_plevel(req_plevel),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .sr_rd_en(sr_rd_en), .sr_wr_en(sr_wr_en),
        .sr_group(sr_group), .sr_regnum(sr_regnum), .sr_plevel(sr_plevel),
        .sr_wr_val(sr_wr_val), .sr_rd_valid(sr_rd_valid), .sr_rd_val(sr_rd_val)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    bit          rq_pend [NREQ];
    bit          rq_write[NREQ];
    logic [4:0]  rq_grp  [NREQ];
    logic [2:0]  rq_reg  [NREQ];
    logic [1:0]  rq_pl   [NREQ];
    logic [63:0] rq_wd   [NREQ];

    bit          m_busy, m_write, m_denied, exp_err;
    int          m_ptr, m_owner;
    logic [4:0]  m_grp;
    logic [2:0]  m_reg;
    logic [1:0]  m_pl;
    logic [63:0] m_wd, pulse_val, exp_rdata;
    int          strobe_cyc, rsp_cyc, pulse_cyc;
    bit          hs_flag;
    int          hs_owner, hs_cyc;
    int          next_k    = -1;
    bit          use_val   = 1'b0;
    logic [63:0] next_val  = '0;
    bit          rand_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_write = 0; m_denied = 0; exp_err = 0;
        m_ptr = 0; m_owner = 0;
        m_grp = '0; m_reg = '0; m_pl = '0; m_wd = '0;
        pulse_val = '0; exp_rdata = '0;
        strobe_cyc = -1; rsp_cyc = -1; pulse_cyc = -1;
        hs_flag = 0;
    endtask

    task automatic new_req(input int i, input bit wr, input logic [4:0] g, input logic [2:0] r,
                           input logic [1:0] pl, input logic [63:0] d);
        rq_pend[i] = 1; rq_write[i] = wr; rq_grp[i] = g; rq_reg[i] = r; rq_pl[i] = pl; rq_wd[i] = d;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (rand_mode && !rq_pend[i] && $urandom_range(0, 1) == 1)
                new_req(i, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom_range(0, 31)),
                        3'($urandom_range(0, 7)),
                        ($urandom_range(0, 1) == 1) ? 2'd0 : 2'($urandom_range(0, 3)),
                        {$urandom, $urandom});
            req_valid[i]           = rq_pend[i];
            req_write[i]           = rq_pend[i] ? rq_write[i] : 1'($urandom_range(0, 1));
            req_group[5*i +: 5]    = rq_pend[i] ? rq_grp[i] : 5'($urandom_range(0, 31));
            req_regnum[3*i +: 3]   = rq_pend[i] ? rq_reg[i] : 3'($urandom_range(0, 7));
            req_plevel[2*i +: 2]   = rq_pend[i] ? rq_pl[i]  : 2'($urandom_range(0, 3));
            req_wdata[64*i +: 64]  = rq_pend[i] ? rq_wd[i]  : {$urandom, $urandom};
        end
        sr_rd_valid = (cyc == pulse_cyc);
        sr_rd_val   = (cyc == pulse_cyc) ? pulse_val : {$urandom, $urandom};
    endtask

    task automatic check_and_update();
        logic [NREQ-1:0] e_ready, e_rsp;
        bit found;
        int w, lat, idx;
        bit strobe;
        e_ready = '0; e_rsp = '0; found = 0; w = 0;
        if (!m_busy)
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!found && rq_pend[idx]) begin found = 1; w = idx; end
            end
        if (found) e_ready[w] = 1'b1;
        if (cyc == rsp_cyc) e_rsp[m_owner] = 1'b1;
        strobe = (cyc == strobe_cyc) && !m_denied;
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("sr_wr_en",  64'(sr_wr_en),  64'(strobe && m_write));
        chk("sr_rd_en",  64'(sr_rd_en),  64'(strobe && !m_write));
        chk("sr_group",  64'(sr_group),  64'(m_grp));
        chk("sr_regnum", 64'(sr_regnum), 64'(m_reg));
        chk("sr_plevel", 64'(sr_plevel), 64'(m_pl));
        chk("sr_wr_val", sr_wr_val, m_wd);
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        chk("rsp_rdata", rsp_rdata, (cyc == rsp_cyc) ? exp_rdata : 64'd0);
        chk("rsp_err",   64'(rsp_err),   64'((cyc == rsp_cyc) && exp_err));
        hs_flag = 0;
        if (found) begin
            hs_flag = 1; hs_owner = w; hs_cyc = cyc;
            rq_pend[w] = 0;
            m_busy = 1; m_owner = w; m_ptr = (w + 1) % NREQ;
            m_write = rq_write[w]; m_grp = rq_grp[w]; m_reg = rq_reg[w];
            m_pl = rq_pl[w]; m_wd = rq_wd[w];
            m_denied = PRIV_MASK[m_grp] && (m_pl != 2'd0);
            strobe_cyc = cyc + 1;
            if (m_denied || m_write) begin
                rsp_cyc = cyc + 2; exp_rdata = '0; exp_err = m_denied;
            end else begin
                lat = (next_k >= 0) ? next_k : int'($urandom_range(0, TIMEOUT + 1));
                next_k = -1;
                pulse_val = use_val ? next_val : {$urandom, $urandom};
                use_val = 0;
                pulse_cyc = cyc + 1 + lat;
                if (lat >= 1 && lat <= TIMEOUT) begin
                    rsp_cyc = cyc + 2 + lat; exp_rdata = pulse_val; exp_err = 0;
                end else begin
                    rsp_cyc = cyc + 2 + TIMEOUT; exp_rdata = '0; exp_err = 1;
                end
            end
        end else if (m_busy && cyc == rsp_cyc) begin
            m_busy = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive();
        @(negedge clk);
        check_and_update();
    endtask

    task automatic wait_hs(input string name, input int tmo);
        int n;
        n = 0;
        do begin step(); n++; end while (!hs_flag && n < tmo);
        n_checks++;
        if (!hs_flag) begin
            n_err++;
            $display("FAIL %s no handshake within %0d cycles", name, tmo);
        end
    endtask

    task automatic wait_rsp(input string name, input int tmo, output int at);
        int n;
        n = 0;
        do begin step(); n++; end while (rsp_valid == '0 && n < tmo);
        at = cyc;
        n_checks++;
        if (rsp_valid == '0) begin
            n_err++;
            $display("FAIL %s no response within %0d cycles", name, tmo);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) rq_pend[i] = 0;
        req_valid = '0;
        sr_rd_valid = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err",   64'(rsp_err), 64'd0);
        chk("rst_strobes",   64'({sr_rd_en, sr_wr_en}), 64'd0);
        chk("rst_fields",    64'({sr_group, sr_regnum, sr_plevel}), 64'd0);
        chk("rst_wr_val",    sr_wr_val, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int at, prev;
        int order[4];
        for (int i = 0; i < NREQ; i++) rq_pend[i] = 0;
        model_reset();
        #2;
        do_reset();

        // 1: write from requester 0
        new_req(0, 1, 5'd3, 3'd2, 2'd1, 64'hDEAD);
        wait_hs("t1_hs", 5);
        chk("t1_owner", 64'(hs_owner), 64'd0);
        chk("t1_ready", 64'(req_ready), 64'b01);
        step();
        chk("t1_wr_en", 64'({sr_wr_en, sr_rd_en}), 64'b10);
        chk("t1_fields", 64'({sr_group, sr_regnum, sr_plevel}), 64'({5'd3, 3'd2, 2'd1}));
        chk("t1_wr_val", sr_wr_val, 64'hDEAD);
        step();
        chk("t1_rsp", 64'({rsp_valid, rsp_err}), 64'({2'b01, 1'b0}));
        chk("t1_rdata", rsp_rdata, 64'd0);
        step();

        // 2: read from requester 1, data three cycles after rd_en
        new_req(1, 0, 5'd10, 3'd7, 2'd0, 64'h0);
        next_k = 3; use_val = 1; next_val = 64'h1234;
        wait_hs("t2_hs", 5);
        wait_rsp("t2_rsp", 30, at);
        chk("t2_latency", 64'(at - hs_cyc), 64'd5);
        chk("t2_rsp", 64'({rsp_valid, rsp_err}), 64'({2'b10, 1'b0}));
        chk("t2_rdata", rsp_rdata, 64'h1234);
        step();

        // 3: privilege denied
        new_req(0, 0, 5'd10, 3'd7, 2'd1, 64'h0);
        wait_hs("t3_hs", 5);
        step();
        chk("t3_no_strobe", 64'({sr_wr_en, sr_rd_en}), 64'd0);
        step();
        chk("t3_rsp", 64'({rsp_valid, rsp_err}), 64'({2'b01, 1'b1}));
        chk("t3_rdata", rsp_rdata, 64'd0);
        step();

        // 4: timeout (stray rd_valid during ISSUE is ignored)
        new_req(0, 0, 5'd4, 3'd1, 2'd2, 64'h0);
        next_k = 0;
        wait_hs("t4_hs", 5);
        wait_rsp("t4_rsp", 40, at);
        chk("t4_latency", 64'(at - hs_cyc), 64'd18);
        chk("t4_err", 64'(rsp_err), 64'd1);
        chk("t4_rdata", rsp_rdata, 64'd0);
        step();

        // 4b: rd_valid on the final WAIT cycle returns data
        new_req(1, 0, 5'd4, 3'd5, 2'd0, 64'h0);
        next_k = 16; use_val = 1; next_val = 64'hCAFE_F00D;
        wait_hs("t4b_hs", 5);
        wait_rsp("t4b_rsp", 40, at);
        chk("t4b_latency", 64'(at - hs_cyc), 64'd18);
        chk("t4b_err", 64'(rsp_err), 64'd0);
        chk("t4b_rdata", rsp_rdata, 64'hCAFE_F00D);
        step();

        // 6: reset during WAIT drops the transaction
        new_req(1, 0, 5'd10, 3'd6, 2'd0, 64'h0);
        next_k = 1000;
        wait_hs("t6_hs", 5);
        repeat (5) step();
        chk("t6_pre_group", 64'(sr_group), 64'd10);
        do_reset();
        repeat (6) step();

        // 5: both requesters held valid, grants alternate from pointer 0
        new_req(0, 1, 5'd1, 3'd0, 2'd0, 64'h11);
        new_req(1, 1, 5'd2, 3'd1, 2'd0, 64'h22);
        prev = 0;
        for (int j = 0; j < 4; j++) begin
            wait_hs("t5_hs", 10);
            order[j] = hs_owner;
            if (j > 0) chk("t5_gap", 64'(hs_cyc - prev), 64'd3);
            prev = hs_cyc;
            if (j < 2) new_req(hs_owner, 1, 5'(j + 5), 3'(j), 2'd0, 64'(j));
        end
        chk("t5_order", 64'({order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}),
            64'({2'd0, 2'd1, 2'd0, 2'd1}));
        repeat (6) step();

        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        repeat (60) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
